// File: rtl/lpc_reg_write_arbiter.sv
// lpc_reg_write_arbiter
//   Arbitrates the single write port of the LPC register file between the
//   LPC host write strobe and NUM_REQ internal hardware requesters.
//   The host always wins and never stalls; internal requesters are served
//   round-robin, at most one write per two cycles, and are blocked for
//   GUARD_CYC cycles after every host write so a stale hardware write cannot
//   overwrite a value the host just wrote.
//
// Ports
//   LpcClock   in   LPC clock, all logic on the rising edge
//   PciReset   in   asynchronous active-high reset
//   LpcWr      in   one-cycle host write strobe
//   LpcAddr    in   host register address (valid with LpcWr)
//   LpcData    in   host write data (valid with LpcWr)
//   ReqValid   in   per-requester request, held until granted
//   ReqAddr    in   requester i address at [8i+7:8i]
//   ReqData    in   requester i data at [8i+7:8i]
//   ReqGnt     out  one-hot one-cycle grant, coincident with its RegWr
//   RegWr      out  register-file write strobe
//   RegAddr    out  register-file address
//   RegData    out  register-file data
//   WrSrcLpc   out  high with RegWr when the write came from the host
//   Collision  out  host write hit the address of a pending internal request
module lpc_reg_write_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int GUARD_CYC = 4
) (
  input  logic                   LpcClock,
  input  logic                   PciReset,
  input  logic                   LpcWr,
  input  logic [7:0]             LpcAddr,
  input  logic [7:0]             LpcData,
  input  logic [NUM_REQ-1:0]     ReqValid,
  input  logic [8*NUM_REQ-1:0]   ReqAddr,
  input  logic [8*NUM_REQ-1:0]   ReqData,
  output logic [NUM_REQ-1:0]     ReqGnt,
  output logic                   RegWr,
  output logic [7:0]             RegAddr,
  output logic [7:0]             RegData,
  output logic                   WrSrcLpc,
  output logic                   Collision
);

  localparam int LastW = $clog2(NUM_REQ);
  localparam logic [3:0] GuardLoad = 4'(GUARD_CYC);
  localparam logic [LastW-1:0] LastRst = LastW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD} arbState;

  arbState          stateReg, stateNext;
  logic [3:0]       guardReg, guardNext;
  logic [LastW-1:0] lastReg, lastNext;

  logic [NUM_REQ-1:0] gntNext;
  logic               wrNext, srcNext, collNext;
  logic [7:0]         addrNext, dataNext;

  logic [7:0]         reqAddrArr [NUM_REQ];
  logic [7:0]         reqDataArr [NUM_REQ];
  logic [NUM_REQ-1:0] hitVec;

  logic               found;
  logic [LastW-1:0]   winner;

  // Unpack the flat request buses and flag address hits against the host.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gReq
      assign reqAddrArr[gi] = ReqAddr[8*gi +: 8];
      assign reqDataArr[gi] = ReqData[8*gi +: 8];
      assign hitVec[gi]     = ReqValid[gi] && (ReqAddr[8*gi +: 8] == LpcAddr);
    end
  endgenerate

  // Round-robin search starting just after the last winner.
  always_comb begin
    logic [LastW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = LastW'((int'(lastReg) + k) % NUM_REQ);
      if (!found && ReqValid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    guardNext = guardReg;
    lastNext  = lastReg;
    gntNext   = '0;
    wrNext    = 1'b0;
    srcNext   = 1'b0;
    collNext  = 1'b0;
    addrNext  = RegAddr;
    dataNext  = RegData;

    if (LpcWr) begin
      // Host path overrides everything and (re)opens the guard window.
      wrNext    = 1'b1;
      srcNext   = 1'b1;
      addrNext  = LpcAddr;
      dataNext  = LpcData;
      collNext  = |hitVec;
      guardNext = GuardLoad;
      stateNext = GUARD;
    end else begin
      case (stateReg)
        IDLE: begin
          if (found) begin
            gntNext[winner] = 1'b1;
            wrNext          = 1'b1;
            addrNext        = reqAddrArr[winner];
            dataNext        = reqDataArr[winner];
            lastNext        = winner;
            stateNext       = ISSUE;
          end
        end
        // One dead cycle lets the granted requester drop ReqValid.
        ISSUE: stateNext = IDLE;
        GUARD: begin
          if (guardReg <= 4'd1) begin
            guardNext = 4'd0;
            stateNext = IDLE;
          end else begin
            guardNext = guardReg - 4'd1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge LpcClock or posedge PciReset) begin
    if (PciReset) begin
      stateReg  <= IDLE;
      guardReg  <= 4'd0;
      lastReg   <= LastRst;
      ReqGnt    <= '0;
      RegWr     <= 1'b0;
      RegAddr   <= 8'h00;
      RegData   <= 8'h00;
      WrSrcLpc  <= 1'b0;
      Collision <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      guardReg  <= guardNext;
      lastReg   <= lastNext;
      ReqGnt    <= gntNext;
      RegWr     <= wrNext;
      RegAddr   <= addrNext;
      RegData   <= dataNext;
      WrSrcLpc  <= srcNext;
      Collision <= collNext;
    end
  end

endmodule

// File: tb/tb_lpc_reg_write_arbiter.sv
module tb_lpc_reg_write_arbiter;
  localparam int N = 3;
  localparam int G = 4;

  logic           LpcClock = 1'b0;
  logic           PciReset;
  logic           LpcWr;
  logic [7:0]     LpcAddr, LpcData;
  logic [N-1:0]   ReqValid;
  logic [8*N-1:0] ReqAddr, ReqData;
  logic [N-1:0]   ReqGnt;
  logic           RegWr;
  logic [7:0]     RegAddr, RegData;
  logic           WrSrcLpc, Collision;

  int tests = 0;
  int fails = 0;

  lpc_reg_write_arbiter #(.NUM_REQ(N), .GUARD_CYC(G)) dut (
    .LpcClock(LpcClock), .PciReset(PciReset), .LpcWr(LpcWr),
    .LpcAddr(LpcAddr), .LpcData(LpcData), .ReqValid(ReqValid),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqGnt(ReqGnt),
    .RegWr(RegWr), .RegAddr(RegAddr), .RegData(RegData),
    .WrSrcLpc(WrSrcLpc), .Collision(Collision)
  );

  always #5 LpcClock = ~LpcClock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       lpcWr;
    logic [7:0] lpcAddr;
    logic [7:0] lpcData;
    logic [2:0] rv;
    logic [23:0] ra;
    logic [2:0] gnt;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       src;
    logic       coll;
  } vec_t;

  function automatic vec_t mk(logic w, logic [7:0] la, logic [7:0] ld, logic [2:0] rv,
                              logic [23:0] ra, logic [2:0] g, logic ew, logic [7:0] ea,
                              logic [7:0] ed, logic es, logic ec);
    vec_t v;
    v.lpcWr = w; v.lpcAddr = la; v.lpcData = ld; v.rv = rv; v.ra = ra;
    v.gnt = g; v.wr = ew; v.addr = ea; v.data = ed; v.src = es; v.coll = ec;
    return v;
  endfunction

  task automatic step();
    @(posedge LpcClock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] g, input logic w,
                          input logic [7:0] a, input logic [7:0] d, input logic s, input logic c);
    check({tag, ".ReqGnt"}, 32'(ReqGnt), 32'(g));
    check({tag, ".RegWr"}, 32'(RegWr), 32'(w));
    check({tag, ".RegAddr"}, 32'(RegAddr), 32'(a));
    check({tag, ".RegData"}, 32'(RegData), 32'(d));
    check({tag, ".WrSrcLpc"}, 32'(WrSrcLpc), 32'(s));
    check({tag, ".Collision"}, 32'(Collision), 32'(c));
  endtask

  localparam logic [23:0] RA  = {8'h12, 8'h11, 8'h10};
  localparam logic [23:0] RA2 = {8'h12, 8'h07, 8'h10};

  initial begin
    vec_t tbl[$];
    int cnt;
    logic       pend [N];
    logic [7:0] pA [N];
    logic [7:0] pD [N];
    int lastHost, lastSel, lastW, w;
    logic [2:0] eGnt;
    logic eWr, eSrc, eColl;
    logic [7:0] eA, eD;

    // Directed table: round-robin from reset, then host-wins with guard.
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b111, RA, 3'b001, 1, 8'h10, 8'hA0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b111, RA, 3'b000, 0, 8'h10, 8'hA0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b111, RA, 3'b010, 1, 8'h11, 8'hB1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b111, RA, 3'b000, 0, 8'h11, 8'hB1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b111, RA, 3'b100, 1, 8'h12, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b111, RA, 3'b000, 0, 8'h12, 8'hC2, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b111, RA, 3'b001, 1, 8'h10, 8'hA0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b111, RA, 3'b000, 0, 8'h10, 8'hA0, 0, 0));
    tbl.push_back(mk(1, 8'h05, 8'hA5, 3'b010, RA2, 3'b000, 1, 8'h05, 8'hA5, 1, 0));
    for (int i = 0; i < G; i++)
      tbl.push_back(mk(0, 8'h00, 8'h00, 3'b010, RA2, 3'b000, 0, 8'h05, 8'hA5, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b010, RA2, 3'b010, 1, 8'h07, 8'hB1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b000, RA2, 3'b000, 0, 8'h07, 8'hB1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 3'b000, RA2, 3'b000, 0, 8'h07, 8'hB1, 0, 0));

    PciReset = 1'b1; LpcWr = 1'b0; LpcAddr = 8'h00; LpcData = 8'h00;
    ReqValid = '0; ReqAddr = RA; ReqData = {8'hC2, 8'hB1, 8'hA0};
    step(); step();
    checkAll("reset", 3'b000, 0, 8'h00, 8'h00, 0, 0);
    PciReset = 1'b0;

    foreach (tbl[i]) begin
      LpcWr = tbl[i].lpcWr; LpcAddr = tbl[i].lpcAddr; LpcData = tbl[i].lpcData;
      ReqValid = tbl[i].rv; ReqAddr = tbl[i].ra;
      step();
      $display("[TB] vec %0d: gnt=%b wr=%0d addr=%02h src=%0d", i, ReqGnt, RegWr, RegAddr, WrSrcLpc);
      checkAll($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].wr, tbl[i].addr, tbl[i].data,
               tbl[i].src, tbl[i].coll);
    end

    // Collision: host hits the address of requester 2 in the same cycle.
    ReqAddr = {8'h01, 8'h11, 8'h10}; ReqValid = 3'b100;
    LpcWr = 1'b1; LpcAddr = 8'h01; LpcData = 8'h5A;
    step();
    $display("[TB] coll host write: coll=%0d", Collision);
    checkAll("coll.host", 3'b000, 1, 8'h01, 8'h5A, 1, 1);
    LpcWr = 1'b0;
    step();
    check("coll.pulse_end", 32'(Collision), 32'd0);
    cnt = 1;
    while (ReqGnt == 0 && cnt < 20) begin step(); cnt++; end
    $display("[TB] coll grant: gnt=%b after %0d cycles", ReqGnt, cnt);
    check("coll.gnt_delay", 32'(cnt), 32'(G + 1));
    checkAll("coll.gnt", 3'b100, 1, 8'h01, 8'hC2, 0, 0);
    ReqValid = 3'b000;
    step();

    // Back-to-back host writes every 3 cycles keep requester 0 locked out.
    ReqAddr = RA; ReqValid = 3'b001;
    for (int k = 0; k < 4; k++) begin
      LpcWr = 1'b1; LpcAddr = 8'(8'h20 + k); LpcData = 8'(8'h40 + k);
      step();
      $display("[TB] b2b host write %0d: addr=%02h", k, RegAddr);
      checkAll($sformatf("b2b.host%0d", k), 3'b000, 1, 8'(8'h20 + k), 8'(8'h40 + k), 1, 0);
      LpcWr = 1'b0;
      step(); check($sformatf("b2b.nogntA%0d", k), 32'(ReqGnt), 32'd0);
      step(); check($sformatf("b2b.nogntB%0d", k), 32'(ReqGnt), 32'd0);
    end
    cnt = 2;
    while (ReqGnt == 0 && cnt < 20) begin step(); cnt++; end
    $display("[TB] b2b grant: gnt=%b after %0d cycles", ReqGnt, cnt);
    check("b2b.gnt_delay", 32'(cnt), 32'(G + 1));
    checkAll("b2b.gnt", 3'b001, 1, 8'h10, 8'hA0, 0, 0);
    ReqValid = 3'b000;
    step();

    // Reset during ISSUE: pointer must restart at requester 0.
    ReqValid = 3'b111;
    step();
    checkAll("rstI.pre", 3'b010, 1, 8'h11, 8'hB1, 0, 0);
    PciReset = 1'b1;
    #2;
    checkAll("rstI.async", 3'b000, 0, 8'h00, 8'h00, 0, 0);
    step();
    PciReset = 1'b0;
    step();
    $display("[TB] rstI first grant: gnt=%b", ReqGnt);
    checkAll("rstI.gnt0", 3'b001, 1, 8'h10, 8'hA0, 0, 0);
    ReqValid = 3'b011;
    step();
    checkAll("rstI.issue", 3'b000, 0, 8'h10, 8'hA0, 0, 0);

    // Reset during GUARD.
    LpcWr = 1'b1; LpcAddr = 8'h3C; LpcData = 8'hC3;
    step();
    checkAll("rstG.host", 3'b000, 1, 8'h3C, 8'hC3, 1, 0);
    LpcWr = 1'b0;
    step();
    PciReset = 1'b1;
    #2;
    checkAll("rstG.async", 3'b000, 0, 8'h00, 8'h00, 0, 0);
    step();
    PciReset = 1'b0;
    step();
    $display("[TB] rstG first grant: gnt=%b", ReqGnt);
    checkAll("rstG.gnt0", 3'b001, 1, 8'h10, 8'hA0, 0, 0);
    ReqValid = 3'b000;
    step();

    // Randomized traffic against a timestamp-based reference model.
    PciReset = 1'b1;
    step();
    PciReset = 1'b0;
    lastHost = -100; lastSel = -100; lastW = N - 1;
    eA = 8'h00; eD = 8'h00;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pA[i] = 8'h00; pD[i] = 8'h00; end
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] && $urandom_range(15) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i] = 1'b1; pA[i] = 8'($urandom_range(7)); pD[i] = 8'($urandom);
        end
        ReqValid[i] = pend[i];
        ReqAddr[8*i +: 8] = pA[i];
        ReqData[8*i +: 8] = pD[i];
      end
      LpcWr = ($urandom_range(5) == 0);
      LpcAddr = 8'($urandom_range(7));
      LpcData = 8'($urandom);

      eGnt = 3'b000; eWr = 1'b0; eSrc = 1'b0; eColl = 1'b0; w = -1;
      if (LpcWr) begin
        eWr = 1'b1; eSrc = 1'b1; eA = LpcAddr; eD = LpcData;
        for (int i = 0; i < N; i++) if (pend[i] && pA[i] == LpcAddr) eColl = 1'b1;
        lastHost = t;
      end else if (t >= lastHost + G + 1 && t >= lastSel + 2) begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && pend[(lastW + k) % N]) w = (lastW + k) % N;
        end
        if (w >= 0) begin
          eGnt[w] = 1'b1; eWr = 1'b1; eA = pA[w]; eD = pD[w];
          lastW = w; lastSel = t;
        end
      end
      step();
      if (eWr)
        $display("[TB] rnd t=%0d: src=%0d addr=%02h gnt=%b coll=%0d", t, eSrc, eA, eGnt, eColl);
      checkAll($sformatf("rnd%0d", t), eGnt, eWr, eA, eD, eSrc, eColl);
      if (w >= 0) pend[w] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
